// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates, load and clear,
// with a saturating count of shift-class operations and a one-cycle completion pulse.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             so,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] next_po;
  logic             is_shift;
  logic             is_reset_cnt;

  assign op = mode_e'(mode);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_po      = po;
    is_shift     = 1'b0;
    is_reset_cnt = 1'b0;
    case (op)
      MODE_HOLD: next_po = po;
      MODE_SHL: begin
        next_po  = {po[WIDTH-2:0], si};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        next_po  = {si, po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        next_po      = pi;
        is_reset_cnt = 1'b1;
      end
      MODE_ROL: begin
        next_po  = {po[WIDTH-2:0], po[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        next_po  = {po[0], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        next_po  = {po[WIDTH-1], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_CLR: begin
        next_po      = '0;
        is_reset_cnt = 1'b1;
      end
    endcase
  end

  // Serial output taps the bit about to leave in the direction of a left shift/rotate.
  assign so = (op == MODE_SHL || op == MODE_ROL) ? po[WIDTH-1] : po[0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      po   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= en && is_shift && (cnt == CW'(WIDTH - 1));
      if (en) begin
        po <= next_po;
        if (is_reset_cnt)
          cnt <= '0;
        else if (is_shift && cnt < CW'(WIDTH))
          cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pi;
  logic             si;
  logic [WIDTH-1:0] po;
  logic             so;
  logic [CW-1:0]    cnt;
  logic             done;

  int checks   = 0;
  int failures = 0;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .pi   (pi),
    .si   (si),
    .po   (po),
    .so   (so),
    .cnt  (cnt),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] p, input logic s);
    rst  = r;
    en   = e;
    mode = m;
    pi   = p;
    si   = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] p, input logic s);
    set_in(1'b0, 1'b1, m, p, s);
    tick();
  endtask

  task automatic check_state(input string tag, input logic [7:0] epo,
                             input logic [3:0] ecnt, input logic edone);
    check({tag, ".po"},   32'(po),   32'(epo));
    check({tag, ".cnt"},  32'(cnt),  32'(ecnt));
    check({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  logic [7:0] so_seq;

  initial begin
    so_seq = 8'b1010_0101;

    // Reset with a non-hold mode and en high: reset still wins.
    set_in(1'b1, 1'b1, 3'b011, 8'hEE, 1'b1);
    tick();
    check_state("reset", 8'h00, 4'd0, 1'b0);

    // Load A5, shift left 8 times with si=1.
    op(3'b011, 8'hA5, 1'b0);
    check_state("load_a5", 8'hA5, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 3'b001, 8'h00, 1'b1);
      #1;
      check($sformatf("shl_so%0d", i), 32'(so), 32'(so_seq[7-i]));
      tick();
      check($sformatf("shl_cnt%0d", i), 32'(cnt), 32'(i + 1));
      check($sformatf("shl_done%0d", i), 32'(done), 32'(i == 7));
    end
    check("shl_po", 32'(po), 32'h0000_00FF);
    op(3'b000, 8'h00, 1'b0);
    check_state("hold_after", 8'hFF, 4'd8, 1'b0);

    // Rotates.
    op(3'b011, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) op(3'b100, 8'h00, 1'b1);
    check_state("rol3", 8'h0C, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) op(3'b101, 8'h00, 1'b0);
    check_state("ror3", 8'h81, 4'd6, 1'b0);

    // Arithmetic then logical shift right; si ignored by ASR.
    op(3'b011, 8'h90, 1'b0);
    op(3'b110, 8'h00, 1'b0);
    op(3'b110, 8'h00, 1'b0);
    check_state("asr2", 8'hE4, 4'd2, 1'b0);
    op(3'b010, 8'h00, 1'b0);
    check_state("shr1", 8'h72, 4'd3, 1'b0);

    // Freeze with en=0 one shift short of completion, then finish and saturate.
    op(3'b011, 8'h3C, 1'b0);
    for (int i = 0; i < 7; i++) op(3'b001, 8'h00, 1'b1);
    check_state("pre_freeze", 8'h7F, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 3'b001, 8'h00, 1'b1);
      tick();
      check_state($sformatf("frozen%0d", i), 8'h7F, 4'd7, 1'b0);
    end
    op(3'b001, 8'h00, 1'b1);
    check_state("complete", 8'hFF, 4'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      op(3'b001, 8'h00, 1'b1);
      check_state($sformatf("sat%0d", i), 8'hFF, 4'd8, 1'b0);
    end

    // Reset on the completing edge aborts the pulse.
    op(3'b011, 8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) op(3'b001, 8'h00, 1'b0);
    check_state("pre_rst", 8'h80, 4'd7, 1'b0);
    set_in(1'b1, 1'b1, 3'b001, 8'h00, 1'b0);
    tick();
    check_state("rst_abort", 8'h00, 4'd0, 1'b0);
    op(3'b111, 8'h00, 1'b0);
    check_state("clr_after", 8'h00, 4'd0, 1'b0);

    // Load while cnt=7: load wins, no pulse.
    op(3'b011, 8'h12, 1'b0);
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00, 1'b0);
    check("pre_load_cnt", 32'(cnt), 32'd7);
    op(3'b011, 8'h55, 1'b0);
    check_state("load_wins", 8'h55, 4'd0, 1'b0);
    op(3'b000, 8'h00, 1'b0);
    check_state("load_hold", 8'h55, 4'd0, 1'b0);

    // so follows mode combinationally with en=0.
    set_in(1'b0, 1'b0, 3'b001, 8'h00, 1'b0);
    #1;
    check("so_shl_en0", 32'(so), 32'd0);
    set_in(1'b0, 1'b0, 3'b101, 8'h00, 1'b0);
    #1;
    check("so_ror_en0", 32'(so), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  operation enable; en=0 freezes all state.
REQ-005 Port: mode  input  3  operation select (see REQ-010).
REQ-006 Port: pi  input  WIDTH  parallel load data.
REQ-007 Port: si  input  1  serial input bit.
REQ-008 Port: po  output  WIDTH  registered register contents.
REQ-009 Port: so  output  1  serial output, combinational from po and mode.
REQ-010 Port: cnt  output  clog2(WIDTH+1)  registered count of shift-class operations since last load or clear.
REQ-011 Port: done  output  1  registered single-cycle pulse: WIDTH shifts completed since last load or clear.

Function
REQ-012 Mode encoding, applied at a rising edge with en=1 and rst=0: 000 hold; 001 shift left, po <= {po[WIDTH-2:0], si}; 010 shift right, po <= {si, po[WIDTH-1:1]}; 011 load, po <= pi; 100 rotate left, po <= {po[WIDTH-2:0], po[WIDTH-1]}; 101 rotate right, po <= {po[0], po[WIDTH-1:1]}; 110 arithmetic shift right, po <= {po[WIDTH-1], po[WIDTH-1:1]} with si ignored; 111 clear, po <= 0.
REQ-013 Shift-class modes: 001, 010, 100, 101, 110.
REQ-014 so = po[WIDTH-1] when mode is 001 or 100; otherwise po[0]; so follows mode combinationally, including when en=0.
REQ-015 Load (011) or clear (111) with en=1: cnt <= 0 in the same edge as the po update.
REQ-016 Shift-class op with en=1: cnt <= cnt+1 when cnt < WIDTH; cnt saturates at WIDTH and holds there while further shift-class ops execute.
REQ-017 Hold (000) or en=0: cnt unchanged.
REQ-018 done <= 1 exactly on the edge where cnt transitions from WIDTH-1 to WIDTH; done <= 0 on every other edge, so done is high for one cycle only, even if shifting continues or en drops.
REQ-019 Mixing shift-class modes between loads is legal; every such op counts toward cnt.
REQ-020 Load with en=1 while cnt=WIDTH-1: the load wins; cnt <= 0 and done stays 0.
REQ-021 Update latency: po, cnt and done reflect an operation one edge after the edge it is sampled on; no combinational path from pi or si to po.

Reset
REQ-022 rst=1 at a rising edge: po <= 0, cnt <= 0, done <= 0, regardless of en and mode.
REQ-023 Reset has priority over all modes; asserting rst mid-sequence, including on the edge that would complete the count, aborts it and produces no done pulse.
REQ-024 After rst deasserts, first operation is sampled on the next rising edge.

Verification (WIDTH=8)
REQ-025 Load pi=8'hA5, then 8 cycles of mode 001 with si=1 -> po=8'hFF; cnt steps 1..8; done high for exactly the cycle after the 8th shift; so sequence 1,0,1,0,0,1,0,1.
REQ-026 Load 8'h81, then mode 100 three times -> po=8'h0C; then mode 101 three times -> po=8'h81; cnt=6; done never asserted.
REQ-027 Load 8'h90, then mode 110 twice -> po=8'hE4; then mode 010 with si=0 once -> po=8'h72; cnt=3.
REQ-028 Load 8'h3C, 7 shifts, then en=0 for 3 cycles with mode 001 -> po, cnt=7 frozen and done=0; en=1 for one shift -> cnt=8, done pulses once; 4 further shifts -> cnt stays 8, done stays 0.
REQ-029 Load 8'hFF, 7 shifts, rst=1 on the edge where the 8th shift would occur -> po=0, cnt=0, done=0; mode 111 afterward keeps po=0 and cnt=0.
REQ-030 Load 8'h55 with cnt=7 from a prior sequence -> po=8'h55, cnt=0, done=0 on that edge.
